// File: rtl/fetch_buffer_stage_if.sv
// Handshake/bus bundle between the PC/memory side and the stage-1 fetch register.
interface fetch_buffer_stage_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] pc_i;
  logic [DW-1:0] mem_opcode_i;
  logic [DW-1:0] mem_operand_i;
  logic          bb_i;
  logic          flush_i;
  logic          ipc_o;
  logic          dipc_o;
  logic          valid_o;
  logic [AW-1:0] pc_o;
  logic [DW-1:0] ir_o;
  logic [DW-1:0] opr_o;
  logic          od_o;
  logic [7:0]    bubble_cnt_o;

  modport slave (
    input  pc_i, mem_opcode_i, mem_operand_i, bb_i, flush_i,
    output ipc_o, dipc_o, valid_o, pc_o, ir_o, opr_o, od_o, bubble_cnt_o
  );

  modport master (
    output pc_i, mem_opcode_i, mem_operand_i, bb_i, flush_i,
    input  ipc_o, dipc_o, valid_o, pc_o, ir_o, opr_o, od_o, bubble_cnt_o
  );
endinterface

// File: rtl/fetch_buffer_stage.sv
// Stage-1 fetch register: latches PC/opcode/operand, drives PC increment controls,
// inserts bubbles after taken branches and holds while stalled.
module fetch_buffer_stage #(
  parameter int unsigned   AW           = 8,
  parameter int unsigned   DW           = 8,
  parameter logic [DW-1:0] OD_MASK      = DW'(8'hC0),
  parameter logic [DW-1:0] OD_MATCH     = DW'(8'hC0),
  parameter int unsigned   FLUSH_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  fetch_buffer_stage_if.slave  bus
);

  typedef enum logic [1:0] {StRun = 2'd0, StFlush = 2'd1} state_e;

  localparam logic [3:0] FlushInit = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] opr_q, opr_d;
  logic          od_q, od_d;
  logic [7:0]    bub_q, bub_d;
  logic          od_dec;
  logic          advance;

  assign od_dec  = ((bus.mem_opcode_i & OD_MASK) == OD_MATCH);
  assign advance = (state_q == StRun) && !bus.bb_i && !bus.flush_i;

  assign bus.ipc_o  = advance && !od_dec;
  assign bus.dipc_o = advance && od_dec;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    od_d    = od_q;
    bub_d   = bub_q;

    if (bus.flush_i) begin
      valid_d = 1'b0;
      ir_d    = '0;
      opr_d   = '0;
      od_d    = 1'b0;
      if (FLUSH_CYCLES == 0) begin
        state_d = StRun;
      end else begin
        state_d = StFlush;
        cnt_d   = FlushInit;
      end
    end else if (state_q == StFlush) begin
      // Stall is deliberately ignored while draining bubbles.
      valid_d = 1'b0;
      if (cnt_q == 4'd0) begin
        state_d = StRun;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (!bus.bb_i) begin
      valid_d = 1'b1;
      pc_d    = bus.pc_i;
      ir_d    = bus.mem_opcode_i;
      od_d    = od_dec;
      opr_d   = od_dec ? bus.mem_operand_i : '0;
    end

    if (!valid_d && (bub_q != 8'hFF)) begin
      bub_d = bub_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      od_q    <= 1'b0;
      bub_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      od_q    <= od_d;
      bub_q   <= bub_d;
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.pc_o         = pc_q;
  assign bus.ir_o         = ir_q;
  assign bus.opr_o        = opr_q;
  assign bus.od_o         = od_q;
  assign bus.bubble_cnt_o = bub_q;

endmodule
